// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: register offsets and source indices shared by the interrupt controller and its users
package int_ctrl_pkg;
    typedef enum logic [1:0] {
        IC_PEND = 2'd0,
        IC_MASK = 2'd1,
        IC_MODE = 2'd2,
        IC_VEC  = 2'd3
    } ic_reg_e;
    localparam int SRC_TC0 = 0;
    localparam int SRC_TC1 = 1;
    localparam int SRC_EXT = 2;
    localparam int N_HWINT = 6;
endpackage

// File: rtl/int_ctrl_if.sv
// int_ctrl_if: source lines, bridge register port and CPU interrupt/ack signals of the controller
interface int_ctrl_if #(parameter int N_SRC = 6);
    logic [N_SRC-1:0] src_irq;
    logic [1:0]       addr;
    logic             we;
    logic [31:0]      din;
    logic [31:0]      dout;
    logic [5:0]       hwint;
    logic             irq_valid;
    logic [2:0]       irq_id;
    logic             int_ack;
    logic [2:0]       int_ack_id;
    modport slave (
        input  src_irq, addr, we, din, int_ack, int_ack_id,
        output dout, hwint, irq_valid, irq_id
    );
    modport master (
        output src_irq, addr, we, din, int_ack, int_ack_id,
        input  dout, hwint, irq_valid, irq_id
    );
endinterface

// File: rtl/int_sync_edge.sv
// int_sync_edge: synchronises one raw request line and flags its rising edge
module int_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_s,
    output logic o_set
);
    logic r_prev;
    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign o_s = i_d;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            // shift chain, oldest sample in the top bit
            always_ff @(posedge clk) begin
                if (reset) r_sync <= '0;
                else       r_sync <= SYNC_STAGES'({r_sync, i_d});
            end
            assign o_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate
    // prev tracks s every cycle so a mode change never fabricates an edge
    always_ff @(posedge clk) begin
        if (reset) r_prev <= 1'b0;
        else       r_prev <= o_s;
    end
    assign o_set = o_s & ~r_prev;
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: latches, masks and prioritises peripheral interrupt requests for the CPU HWInt input
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int         N_SRC       = 6,
    parameter int         SYNC_STAGES = 2,
    parameter logic [5:0] MASK_RESET  = 6'h3f
) (
    input logic        clk,
    input logic        reset,
    int_ctrl_if.slave  bus
);
    logic [N_SRC-1:0] r_pend, r_mask, r_mode;
    logic [5:0]       r_hwint;
    logic             r_irq_valid;
    logic [2:0]       r_irq_id;
    logic [N_SRC-1:0] w_s, w_set, w_ack, w_w1c, w_pend_nxt, w_mask_nxt;
    logic [5:0]       w_hw_nxt;
    logic [31:0]      w_rd;

    // lowest-numbered set bit wins
    function automatic logic [2:0] f_prio(input logic [5:0] v);
        f_prio = 3'd0;
        for (int k = 5; k >= 0; k--) if (v[k]) f_prio = 3'(k);
    endfunction

    generate
        for (genvar i = 0; i < N_SRC; i++) begin : g_src
            int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_se (
                .clk   (clk),
                .reset (reset),
                .i_d   (bus.src_irq[i]),
                .o_s   (w_s[i]),
                .o_set (w_set[i])
            );
        end
    endgenerate

    // decode clears; out-of-range ack ids match no bit
    always_comb begin
        w_ack = '0;
        for (int k = 0; k < N_SRC; k++) w_ack[k] = bus.int_ack && (bus.int_ack_id == 3'(k));
        w_w1c = (bus.we && bus.addr == IC_PEND) ? bus.din[N_SRC-1:0] : '0;
    end

    // edge bits latch with set winning over clear; level bits follow the synchronised line
    assign w_pend_nxt = (r_mode & (w_set | (r_pend & ~(w_w1c | w_ack)))) | (~r_mode & w_s);
    assign w_mask_nxt = (bus.we && bus.addr == IC_MASK) ? bus.din[N_SRC-1:0] : r_mask;

    // masked view presented to the CPU, zero-extended to the full HWInt width
    always_comb begin
        w_hw_nxt = '0;
        w_hw_nxt[N_SRC-1:0] = w_pend_nxt & w_mask_nxt;
    end

    // register file and registered CPU-side outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend      <= '0;
            r_mask      <= MASK_RESET[N_SRC-1:0];
            r_mode      <= '0;
            r_hwint     <= '0;
            r_irq_valid <= 1'b0;
            r_irq_id    <= 3'd0;
        end else begin
            r_pend      <= w_pend_nxt;
            r_mask      <= w_mask_nxt;
            if (bus.we && bus.addr == IC_MODE) r_mode <= bus.din[N_SRC-1:0];
            r_hwint     <= w_hw_nxt;
            r_irq_valid <= |w_hw_nxt;
            r_irq_id    <= f_prio(w_hw_nxt);
        end
    end

    // combinational read mux, unused upper bits read zero
    always_comb begin
        w_rd = '0;
        w_rd[N_SRC-1:0] = bus.addr == IC_PEND ? r_pend : bus.addr == IC_MASK ? r_mask : r_mode;
        bus.dout = bus.addr == IC_VEC ? {r_irq_valid, 28'b0, r_irq_id} : w_rd;
    end

    assign bus.hwint     = r_hwint;
    assign bus.irq_valid = r_irq_valid;
    assign bus.irq_id    = r_irq_id;
endmodule
